wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback-side producer for the 4-thread banked register file. Merges two result sources into one
//  registered write per cycle on the regfile write interface (data_WB/ctrl_WB/reg_wraddr/thread_sel_WB).
//  Source A: ALU pipeline (fixed timing, cannot stall). Source B: memory/HW-accelerator (valid/ready).
//  B results are buffered in a FIFO. Writes suppress read port A of the targeted bank; bank_wr_busy flags this to ID.
// PARAMETERS
//  D_WIDTH      64  result/register data width
//  FIFO_DEPTH   4   source-B buffer entries (power of 2, >=2)
//  STARVE_LIMIT 8   cycles a B entry may wait at FIFO head before alu_hold is raised
// PORTS
//  clk            in   1        clock, rising edge
//  reset_n        in   1        async active-low reset
//  alu_valid      in   1        source-A result valid this cycle (always consumed)
//  alu_thread     in   4        source-A thread select, one-hot
//  alu_rd         in   5        source-A destination register
//  alu_data       in   D_WIDTH  source-A result
//  acc_valid      in   1        source-B result valid
//  acc_ready      out  1        source-B may transfer (FIFO not full)
//  acc_thread     in   4        source-B thread select, one-hot
//  acc_rd         in   5        source-B destination register
//  acc_data       in   D_WIDTH  source-B result
//  alu_hold       out  1        request: upstream presents no alu_valid next cycle
//  data_WB        out  D_WIDTH  write data to regfile
//  ctrl_WB        out  1        write enable to regfile
//  reg_wraddr     out  5        write register index
//  thread_sel_WB  out  4        write thread, one-hot
//  bank_wr_busy   out  2        [0]=bank1 (threads 0/2), [1]=bank2 (threads 1/3) written this cycle
//  proto_err      out  1        sticky: alu_valid seen while alu_hold was high
// BEHAVIOUR
//  Reset: all outputs 0 except acc_ready=1; FIFO empty; starve counter 0; proto_err 0.
//  Transfer B: acc_valid & acc_ready at edge N. acc_ready = !full (registered count, not comb on acc_valid).
//  Arbitration each cycle (select one candidate S):
//   1) alu_valid -> S=A.  2) else FIFO non-empty -> S=FIFO head (pop).  3) else acc_valid&acc_ready -> S=B bypass (no push).
//  Push into FIFO when B transfers and not bypassed. Push and pop same cycle when full: pop frees, push accepted
//   only if acc_ready was 1 (full => acc_ready 0, no push).
//  Output register: at edge after S chosen: data_WB/reg_wraddr/thread_sel_WB <= S fields;
//   ctrl_WB <= 1 if S exists and rd!=0, else 0. rd==0 consumes slot/pops FIFO but ctrl_WB=0 (x0 never written).
//   When ctrl_WB=0, other WB outputs hold previous value.
//  Latency: A result at cycle N -> ctrl_WB at N+1. B bypass N -> N+1. Buffered B: >=N+2.
//  bank_wr_busy = {ctrl_WB&(thread_sel_WB[1]|thread_sel_WB[3]), ctrl_WB&(thread_sel_WB[0]|thread_sel_WB[2])} (comb from regs).
//  Starvation: counter increments each cycle FIFO non-empty and alu_valid=1 (head blocked); clears on pop or empty.
//   Counter reaches STARVE_LIMIT -> alu_hold=1 (registered) for exactly one cycle; counter clears.
//   alu_hold cycle: head pops (alu_valid expected 0). If alu_valid=1 anyway: A still wins, proto_err<=1, counter restarts.
//  thread_sel is passed unchecked; non-one-hot input is forwarded as-is.
//  Reset mid-operation: FIFO contents discarded, ctrl_WB drops 0 immediately (async).
// TESTING
//  ALU only: alu_valid, thread 0001, rd=5, data=0xA5 -> next cycle ctrl_WB=1, reg_wraddr=5, bank_wr_busy=01.
//  Simultaneous A(thread 0010,rd 3) and B(thread 1000,rd 7) at N -> A written N+1, B written N+2, bank_wr_busy=10 both.
//  rd=0 on A -> ctrl_WB=0 next cycle; FIFO-held rd=0 entry popped with no write.
//  Fill: alu_valid held 1, push 4 B entries -> acc_ready=0 after 4th; no 5th accepted; order preserved on drain.
//  Starvation: alu_valid continuous, 1 B entry -> alu_hold pulse after 8 blocked cycles; drop alu_valid -> entry written.
//  Ignore hold: alu_valid=1 during alu_hold -> A written, proto_err=1 and stays until reset_n low.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the fixed-timing ALU result stream (source A) with
// the buffered memory/accelerator stream (source B) into one registered
// register-file write per cycle, and reports per-bank write activity.
//
// Handshake (source B): a transfer happens at a rising edge where
// acc_valid && acc_ready. acc_ready depends only on the registered FIFO count,
// never on acc_valid, so the producer may hold acc_valid without a comb loop.
// Source A has no handshake: alu_valid is always consumed. alu_hold asks the
// upstream to leave the following cycle empty so the FIFO head can drain.
module wb_arbiter #(
  parameter int D_WIDTH      = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               alu_valid,
  input  logic [3:0]         alu_thread,
  input  logic [4:0]         alu_rd,
  input  logic [D_WIDTH-1:0] alu_data,
  input  logic               acc_valid,
  output logic               acc_ready,
  input  logic [3:0]         acc_thread,
  input  logic [4:0]         acc_rd,
  input  logic [D_WIDTH-1:0] acc_data,
  output logic               alu_hold,
  output logic [D_WIDTH-1:0] data_WB,
  output logic               ctrl_WB,
  output logic [4:0]         reg_wraddr,
  output logic [3:0]         thread_sel_WB,
  output logic [1:0]         bank_wr_busy,
  output logic               proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [3:0]         thread;
    logic [4:0]         rd;
    logic [D_WIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  alu_hold_q, alu_hold_d;
  logic                  proto_err_q, proto_err_d;
  wb_entry_t             wb_q, wb_d;
  logic                  ctrl_q, ctrl_d;

  logic                  fifo_empty;
  logic                  acc_fire;
  logic                  pop;
  logic                  push;
  logic                  sel_valid;
  wb_entry_t             sel;

  assign fifo_empty = (count_q == '0);
  assign acc_ready  = (count_q != (AW+1)'(FIFO_DEPTH));
  assign acc_fire   = acc_valid & acc_ready;

  // Pick this cycle's winner: A always, else FIFO head, else B straight through.
  always_comb begin
    pop       = 1'b0;
    push      = 1'b0;
    sel_valid = 1'b0;
    sel       = '{thread: alu_thread, rd: alu_rd, data: alu_data};
    if (alu_valid) begin
      sel_valid = 1'b1;
      push      = acc_fire;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
      sel       = mem_q[rd_ptr_q];
      push      = acc_fire;
    end else if (acc_fire) begin
      sel_valid = 1'b1;
      sel       = '{thread: acc_thread, rd: acc_rd, data: acc_data};
    end
  end

  // FIFO pointer/count bookkeeping and the registered write port.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wb_d     = wb_q;
    ctrl_d   = 1'b0;
    if (sel_valid && sel.rd != 5'd0) begin
      wb_d   = sel;
      ctrl_d = 1'b1;
    end
  end

  // Starvation watchdog: count blocked head cycles, pulse alu_hold at the limit.
  always_comb begin
    starve_d    = starve_q;
    alu_hold_d  = 1'b0;
    proto_err_d = proto_err_q | (alu_valid & alu_hold_q);
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_valid) begin
      if (starve_q == CW'(STARVE_LIMIT - 1)) begin
        starve_d   = '0;
        alu_hold_d = 1'b1;
      end else begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  // State registers; reset discards FIFO contents and any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      alu_hold_q  <= 1'b0;
      proto_err_q <= 1'b0;
      wb_q        <= '0;
      ctrl_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      alu_hold_q  <= alu_hold_d;
      proto_err_q <= proto_err_d;
      wb_q        <= wb_d;
      ctrl_q      <= ctrl_d;
    end
  end

  // FIFO storage; only the slot being pushed is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{thread: acc_thread, rd: acc_rd, data: acc_data};
    end
  end

  assign data_WB       = wb_q.data;
  assign reg_wraddr    = wb_q.rd;
  assign thread_sel_WB = wb_q.thread;
  assign ctrl_WB       = ctrl_q;
  assign alu_hold      = alu_hold_q;
  assign proto_err     = proto_err_q;
  assign bank_wr_busy  = {ctrl_q & (wb_q.thread[1] | wb_q.thread[3]),
                          ctrl_q & (wb_q.thread[0] | wb_q.thread[2])};

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: feature tasks drive stimulus and check inline; every
// expected register-file write is queued when driven and compared in order
// when ctrl_WB appears.
module tb_wb_arbiter;

  localparam int D_WIDTH = 64;
  localparam int EW      = 4 + 5 + D_WIDTH;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               alu_valid = 1'b0;
  logic [3:0]         alu_thread = '0;
  logic [4:0]         alu_rd = '0;
  logic [D_WIDTH-1:0] alu_data = '0;
  logic               acc_valid = 1'b0;
  logic               acc_ready;
  logic [3:0]         acc_thread = '0;
  logic [4:0]         acc_rd = '0;
  logic [D_WIDTH-1:0] acc_data = '0;
  logic               alu_hold;
  logic [D_WIDTH-1:0] data_WB;
  logic               ctrl_WB;
  logic [4:0]         reg_wraddr;
  logic [3:0]         thread_sel_WB;
  logic [1:0]         bank_wr_busy;
  logic               proto_err;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  wb_arbiter #(.D_WIDTH(D_WIDTH), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_thread(alu_thread), .alu_rd(alu_rd), .alu_data(alu_data),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_thread(acc_thread), .acc_rd(acc_rd),
    .acc_data(acc_data), .alu_hold(alu_hold), .data_WB(data_WB), .ctrl_WB(ctrl_WB),
    .reg_wraddr(reg_wraddr), .thread_sel_WB(thread_sel_WB), .bank_wr_busy(bank_wr_busy),
    .proto_err(proto_err)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ent(input logic [3:0] t, input logic [4:0] r,
                                        input logic [D_WIDTH-1:0] d);
    return {t, r, d};
  endfunction

  // Driver tasks
  task automatic drive_a(input logic [3:0] t, input logic [4:0] r, input logic [D_WIDTH-1:0] d);
    alu_valid = 1'b1; alu_thread = t; alu_rd = r; alu_data = d;
    if (r != 5'd0) exp_q.push_back(ent(t, r, d));
  endtask

  task automatic drive_b(input logic [3:0] t, input logic [4:0] r, input logic [D_WIDTH-1:0] d,
                         input bit expect_accept);
    acc_valid = 1'b1; acc_thread = t; acc_rd = r; acc_data = d;
    if (expect_accept && r != 5'd0) exp_q.push_back(ent(t, r, d));
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0;
    acc_valid = 1'b0;
  endtask

  // Advance one clock and let the scoreboard consume any write produced.
  task automatic tick();
    logic [EW-1:0] exp;
    @(posedge clk);
    #1;
    if (ctrl_WB === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write got=%h required=none",
                 {thread_sel_WB, reg_wraddr, data_WB});
      end else begin
        exp = exp_q.pop_front();
        if ({thread_sel_WB, reg_wraddr, data_WB} !== exp) begin
          errors++;
          $display("FAIL sb_write got=%h required=%h", {thread_sel_WB, reg_wraddr, data_WB}, exp);
        end
      end
    end
  endtask

  task automatic apply_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({ctrl_WB, data_WB, reg_wraddr, thread_sel_WB, bank_wr_busy, alu_hold, proto_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b/%h/%0d/%b/%b/%b/%b required=all_zero",
               ctrl_WB, data_WB, reg_wraddr, thread_sel_WB, bank_wr_busy, alu_hold, proto_err);
    end
    checks++;
    if (acc_ready !== 1'b1) begin errors++; $display("FAIL reset_acc_ready got=%b required=1", acc_ready); end
    release_reset();
  endtask

  task automatic test_alu_only();
    drive_a(4'b0001, 5'd5, 64'hA5);
    tick();
    drive_idle();
    checks++;
    if (ctrl_WB !== 1'b1 || reg_wraddr !== 5'd5 || bank_wr_busy !== 2'b01) begin
      errors++;
      $display("FAIL alu_only got=ctrl%b rd%0d busy%b required=ctrl1 rd5 busy01",
               ctrl_WB, reg_wraddr, bank_wr_busy);
    end
    tick();
    checks++;
    if (ctrl_WB !== 1'b0 || bank_wr_busy !== 2'b00) begin
      errors++;
      $display("FAIL alu_idle got=ctrl%b busy%b required=ctrl0 busy00", ctrl_WB, bank_wr_busy);
    end
  endtask

  task automatic test_simultaneous();
    drive_a(4'b0010, 5'd3, 64'h1111_2222_3333_4444);
    drive_b(4'b1000, 5'd7, 64'h5555_6666_7777_8888, 1'b1);
    tick();
    drive_idle();
    checks++;
    if (ctrl_WB !== 1'b1 || reg_wraddr !== 5'd3 || bank_wr_busy !== 2'b10) begin
      errors++;
      $display("FAIL simul_a got=ctrl%b rd%0d busy%b required=ctrl1 rd3 busy10",
               ctrl_WB, reg_wraddr, bank_wr_busy);
    end
    tick();
    checks++;
    if (ctrl_WB !== 1'b1 || reg_wraddr !== 5'd7 || bank_wr_busy !== 2'b10) begin
      errors++;
      $display("FAIL simul_b got=ctrl%b rd%0d busy%b required=ctrl1 rd7 busy10",
               ctrl_WB, reg_wraddr, bank_wr_busy);
    end
    tick();
  endtask

  task automatic test_rd_zero();
    drive_a(4'b0001, 5'd0, 64'hDEAD);
    tick();
    drive_idle();
    checks++;
    if (ctrl_WB !== 1'b0 || reg_wraddr !== 5'd7) begin
      errors++;
      $display("FAIL rd0_alu got=ctrl%b rd%0d required=ctrl0 rd7(held)", ctrl_WB, reg_wraddr);
    end
    drive_a(4'b0100, 5'd1, 64'h0101);
    drive_b(4'b0010, 5'd0, 64'hBEEF, 1'b1);
    tick();
    drive_idle();
    tick();
    checks++;
    if (ctrl_WB !== 1'b0) begin errors++; $display("FAIL rd0_fifo_pop got=ctrl%b required=ctrl0", ctrl_WB); end
    // A bypass only happens on an empty FIFO, so this proves the rd0 entry left.
    drive_b(4'b0100, 5'd9, 64'h9999, 1'b1);
    tick();
    drive_idle();
    checks++;
    if (ctrl_WB !== 1'b1 || reg_wraddr !== 5'd9 || bank_wr_busy !== 2'b01) begin
      errors++;
      $display("FAIL bypass got=ctrl%b rd%0d busy%b required=ctrl1 rd9 busy01",
               ctrl_WB, reg_wraddr, bank_wr_busy);
    end
    tick();
  endtask

  task automatic test_fill();
    logic [D_WIDTH-1:0] bd [4];
    for (int k = 0; k < 4; k++) bd[k] = {$urandom(), $urandom()};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (acc_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%b required=1", k, acc_ready); end
      drive_a(4'b0001, 5'(10 + k), {$urandom(), $urandom()});
      acc_valid = 1'b1; acc_thread = 4'(1 << k); acc_rd = 5'(20 + k); acc_data = bd[k];
      tick();
    end
    checks++;
    if (acc_ready !== 1'b0) begin errors++; $display("FAIL fill_full got=%b required=0", acc_ready); end
    drive_a(4'b0001, 5'd14, {$urandom(), $urandom()});
    drive_b(4'b1111, 5'd30, 64'hFFFF, 1'b0);
    for (int k = 0; k < 4; k++) exp_q.push_back(ent(4'(1 << k), 5'(20 + k), bd[k]));
    tick();
    drive_idle();
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fill_drain got=%0d_left required=0", exp_q.size()); end
  endtask

  // Hold A busy with one B entry queued; returns blocked edges until alu_hold.
  task automatic starve_until_hold(output int n);
    drive_a(4'b0001, 5'd2, {$urandom(), $urandom()});
    drive_b(4'b0010, 5'd17, 64'h0BAD_F00D, 1'b0);
    tick();
    acc_valid = 1'b0;
    n = 0;
    while (alu_hold !== 1'b1 && n < 20) begin
      drive_a(4'b0001, 5'($urandom_range(1, 31)), {$urandom(), $urandom()});
      tick();
      n++;
    end
  endtask

  task automatic test_starvation();
    int n;
    starve_until_hold(n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL starve_cycles got=%0d required=8", n); end
    drive_idle();
    exp_q.push_back(ent(4'b0010, 5'd17, 64'h0BAD_F00D));
    tick();
    checks++;
    if (alu_hold !== 1'b0 || ctrl_WB !== 1'b1 || reg_wraddr !== 5'd17 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL starve_drain got=hold%b ctrl%b rd%0d perr%b required=hold0 ctrl1 rd17 perr0",
               alu_hold, ctrl_WB, reg_wraddr, proto_err);
    end
    tick();
  endtask

  task automatic test_ignore_hold();
    int n;
    starve_until_hold(n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL ignore_cycles got=%0d required=8", n); end
    drive_a(4'b1000, 5'd29, 64'h2929);
    tick();
    drive_idle();
    checks++;
    if (ctrl_WB !== 1'b1 || reg_wraddr !== 5'd29 || proto_err !== 1'b1 || alu_hold !== 1'b0) begin
      errors++;
      $display("FAIL ignore_a got=ctrl%b rd%0d perr%b hold%b required=ctrl1 rd29 perr1 hold0",
               ctrl_WB, reg_wraddr, proto_err, alu_hold);
    end
    exp_q.push_back(ent(4'b0010, 5'd17, 64'h0BAD_F00D));
    repeat (4) tick();
    checks++;
    if (proto_err !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_sticky got=perr%b left%0d required=perr1 left0", proto_err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    drive_a(4'b0001, 5'd4, 64'h4444);
    drive_b(4'b0100, 5'd6, 64'h6666, 1'b0);
    tick();
    drive_idle();
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ctrl_WB !== 1'b0 || proto_err !== 1'b0 || acc_ready !== 1'b1 || bank_wr_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid got=ctrl%b perr%b ready%b busy%b required=ctrl0 perr0 ready1 busy00",
               ctrl_WB, proto_err, acc_ready, bank_wr_busy);
    end
    exp_q.delete();
    release_reset();
    // The discarded FIFO entry must never surface as a write.
    repeat (4) tick();
    checks++;
    if (ctrl_WB !== 1'b0) begin errors++; $display("FAIL reset_discard got=ctrl%b required=0", ctrl_WB); end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_simultaneous();
    test_rd_zero();
    test_fill();
    test_starvation();
    test_ignore_hold();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue got=%0d required=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
